// File: rtl/loctag_adc_array_rx.sv
// rtl/loctag_adc_array_rx.sv - multi-channel serial ADC capture with shared cs/clk and hysteresis detect
module loctag_adc_array_rx #(
  parameter int N_CH       = 2,
  parameter int ADC_BITS   = 12,
  parameter int LEAD_BITS  = 4,
  parameter int FRAME_CLKS = 16,
  parameter int CLK_DIV    = 2,
  parameter int CONV_GAP   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     single,
  input  logic                     start,
  input  logic [ADC_BITS-1:0]      thresh_hi,
  input  logic [ADC_BITS-1:0]      thresh_lo,
  output logic                     adc_cs,
  output logic                     adc_clk,
  input  logic [N_CH-1:0]          adc_so,
  output logic [N_CH*ADC_BITS-1:0] sample,
  output logic                     sample_valid,
  output logic [N_CH-1:0]          detect,
  output logic                     busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int GAP_W = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CONV_GAP - 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t                     state;
  logic [DIV_W-1:0]           div_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [GAP_W-1:0]           gap_cnt;
  logic [N_CH*ADC_BITS-1:0]   shreg;
  logic [N_CH-1:0]            detect_next;
  logic                       in_data;

  // Only the ADC_BITS data bits after the leading bits enter the shift registers.
  always_comb begin
    in_data = (32'(bit_cnt) >= 32'(LEAD_BITS)) &&
              (32'(bit_cnt) < 32'(LEAD_BITS + ADC_BITS));
  end

  // Set wins over clear, so an inverted threshold pair still behaves deterministically.
  always_comb begin
    detect_next = detect;
    for (int i = 0; i < N_CH; i++) begin
      if (shreg[i*ADC_BITS +: ADC_BITS] >= thresh_hi)
        detect_next[i] = 1'b1;
      else if (shreg[i*ADC_BITS +: ADC_BITS] < thresh_lo)
        detect_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      shreg        <= '0;
      adc_cs       <= 1'b1;
      adc_clk      <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      detect       <= '0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (!single || start)) begin
            state   <= FRAME;
            adc_cs  <= 1'b0;
            adc_clk <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        FRAME: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!adc_clk) begin
              // End of low phase: capture on the same edge that raises adc_clk.
              adc_clk <= 1'b1;
              if (in_data) begin
                for (int i = 0; i < N_CH; i++)
                  shreg[i*ADC_BITS +: ADC_BITS] <= {shreg[i*ADC_BITS +: ADC_BITS-1], adc_so[i]};
              end
            end else if (bit_cnt == BIT_LAST) begin
              state        <= GAP;
              adc_cs       <= 1'b1;
              busy         <= 1'b0;
              sample_valid <= 1'b1;
              sample       <= shreg;
              detect       <= detect_next;
              gap_cnt      <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              adc_clk <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (enable && !single) begin
              state   <= FRAME;
              adc_cs  <= 1'b0;
              adc_clk <= 1'b0;
              busy    <= 1'b1;
              div_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loctag_adc_array_rx.sv
// tb/tb_loctag_adc_array_rx.sv - randomized self-checking bench with ADC models and a detect reference
module tb_loctag_adc_array_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Default instance: 2 channels, CLK_DIV=2
  logic        rst_a, en_a, single_a, start_a;
  logic [11:0] hi_a, lo_a;
  logic        cs_a, sclk_a, valid_a, busy_a;
  logic [1:0]  so_a, det_a;
  logic [23:0] sample_a;

  // Fast wide instance: 4 channels, CLK_DIV=1
  logic        rst_b, en_b, single_b, start_b;
  logic [11:0] hi_b, lo_b;
  logic        cs_b, sclk_b, valid_b, busy_b;
  logic [3:0]  so_b, det_b;
  logic [47:0] sample_b;

  loctag_adc_array_rx dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .single(single_a), .start(start_a),
    .thresh_hi(hi_a), .thresh_lo(lo_a), .adc_cs(cs_a), .adc_clk(sclk_a), .adc_so(so_a),
    .sample(sample_a), .sample_valid(valid_a), .detect(det_a), .busy(busy_a)
  );

  loctag_adc_array_rx #(.N_CH(4), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .single(single_b), .start(start_b),
    .thresh_hi(hi_b), .thresh_lo(lo_b), .adc_cs(cs_b), .adc_clk(sclk_b), .adc_so(so_b),
    .sample(sample_b), .sample_valid(valid_b), .detect(det_b), .busy(busy_b)
  );

  // ADC models: present frame word MSB first, advancing on each adc_clk rise while selected
  logic [15:0] word_a [2];
  logic [15:0] word_b [4];
  int idx_a = 0;
  int idx_b = 0;
  always @(posedge sclk_a or posedge cs_a) idx_a <= cs_a ? 0 : idx_a + 1;
  always @(posedge sclk_b or posedge cs_b) idx_b <= cs_b ? 0 : idx_b + 1;
  always_comb begin
    for (int i = 0; i < 2; i++) so_a[i] = (idx_a < 16) ? word_a[i][4'(15 - idx_a)] : 1'b0;
    for (int i = 0; i < 4; i++) so_b[i] = (idx_b < 16) ? word_b[i][4'(15 - idx_b)] : 1'b0;
  end

  logic det_m_a [2];
  logic det_m_b [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic upd(input logic cur, input logic [11:0] s,
                               input logic [11:0] hi, input logic [11:0] lo);
    if (s >= hi) return 1'b1;
    if (s < lo) return 1'b0;
    return cur;
  endfunction

  task automatic frame_a(input logic [15:0] w0, input logic [15:0] w1, output int fall_cyc);
    int n, rises, lows;
    logic prev;
    word_a[0] = w0;
    word_a[1] = w1;
    n = 0;
    while (cs_a !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    fall_cyc = cyc;
    if (cs_a !== 1'b0) begin
      check("a_cs_fall_timeout", 64'(cs_a), 64'(0));
      return;
    end
    n = 0; rises = 0; lows = 0; prev = sclk_a;
    while (cs_a === 1'b0 && n < 300) begin
      if (sclk_a === 1'b0) lows++;
      @(negedge clk); n++;
      if (prev === 1'b0 && sclk_a === 1'b1) rises++;
      prev = sclk_a;
    end
    check("a_frame_len", 64'(n), 64'(64));
    check("a_sclk_rises", 64'(rises), 64'(16));
    check("a_sclk_low_cycles", 64'(lows), 64'(32));
    check("a_valid", 64'(valid_a), 64'(1));
    check("a_busy_gap", 64'(busy_a), 64'(0));
    det_m_a[0] = upd(det_m_a[0], w0[11:0], hi_a, lo_a);
    det_m_a[1] = upd(det_m_a[1], w1[11:0], hi_a, lo_a);
    check("a_sample0", 64'(sample_a[11:0]), 64'(w0[11:0]));
    check("a_sample1", 64'(sample_a[23:12]), 64'(w1[11:0]));
    check("a_detect", 64'(det_a), 64'({det_m_a[1], det_m_a[0]}));
    @(negedge clk);
    check("a_valid_drop", 64'(valid_a), 64'(0));
    check("a_sample_hold", 64'(sample_a), 64'({w1[11:0], w0[11:0]}));
  endtask

  initial begin
    int f0, f1, n, falls, valids, prev_cs;
    logic [15:0] w0, w1;
    logic [11:0] seq [5];
    logic        seq_det [5];
    seq = '{12'd500, 12'd850, 12'd700, 12'd599, 12'd700};
    seq_det = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_a = 1'b1; en_a = 1'b0; single_a = 1'b0; start_a = 1'b0; hi_a = 12'd800; lo_a = 12'd600;
    rst_b = 1'b1; en_b = 1'b0; single_b = 1'b0; start_b = 1'b0; hi_b = 12'd800; lo_b = 12'd600;
    for (int i = 0; i < 2; i++) begin word_a[i] = '0; det_m_a[i] = 1'b0; end
    for (int i = 0; i < 4; i++) begin word_b[i] = '0; det_m_b[i] = 1'b0; end
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(cs_a), 64'(1));
    check("rst_sclk", 64'(sclk_a), 64'(1));
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cs", 64'(cs_a), 64'(1));
    check("idle_sample", 64'(sample_a), 64'(0));
    check("idle_valid", 64'(valid_a), 64'(0));
    check("idle_detect", 64'(det_a), 64'(0));
    check("idle_busy", 64'(busy_a), 64'(0));

    // Continuous mode: latency, frame shape, period
    word_a[0] = 16'h0ABC; word_a[1] = 16'h0001;
    en_a = 1'b1;
    @(negedge clk);
    check("cs_fall_latency", 64'(cs_a), 64'(0));
    check("busy_frame", 64'(busy_a), 64'(1));
    frame_a(16'h0ABC, 16'h0001, f0);
    frame_a(16'hFABC, 16'hF001, f1);
    check("period", 64'(f1 - f0), 64'(68));

    // Hysteresis sequence on channel 0
    for (int k = 0; k < 5; k++) begin
      w0 = {4'($urandom), seq[k]};
      w1 = 16'($urandom);
      frame_a(w0, w1, f0);
      check("seq_detect0", 64'(det_a[0]), 64'(seq_det[k]));
    end

    // Randomized frames with random thresholds, including boundary hits and lo>hi
    for (int r = 0; r < 10; r++) begin
      hi_a = 12'($urandom_range(0, 4095));
      lo_a = 12'($urandom_range(0, 4095));
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      case ($urandom_range(0, 3))
        0: w0[11:0] = hi_a;
        1: w0[11:0] = lo_a;
        2: w1[11:0] = hi_a - 12'd1;
        default: ;
      endcase
      frame_a(w0, w1, f0);
    end

    // Single-shot: drop enable, settle in IDLE, then one triggered frame
    en_a = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin @(negedge clk); if (cs_a === 1'b0) n++; end
    check("idle_no_frame", 64'(n), 64'(0));
    single_a = 1'b1; en_a = 1'b1;
    w0 = 16'($urandom); w1 = 16'($urandom);
    word_a[0] = w0; word_a[1] = w1;
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (cs_a === 1'b0) n++; end
    check("single_no_start", 64'(n), 64'(0));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    falls = 0; valids = 0; prev_cs = 1;
    for (int i = 0; i < 250; i++) begin
      if (i == 20 || i == 30) start_a = 1'b1;
      if (i == 21 || i == 31) start_a = 1'b0;
      if (prev_cs == 1 && cs_a === 1'b0) falls++;
      if (valid_a === 1'b1) valids++;
      prev_cs = int'(cs_a);
      @(negedge clk);
    end
    check("single_falls", 64'(falls), 64'(1));
    check("single_valids", 64'(valids), 64'(1));
    check("single_end_cs", 64'(cs_a), 64'(1));
    check("single_end_busy", 64'(busy_a), 64'(0));
    det_m_a[0] = upd(det_m_a[0], w0[11:0], hi_a, lo_a);
    det_m_a[1] = upd(det_m_a[1], w1[11:0], hi_a, lo_a);
    check("single_sample", 64'(sample_a), 64'({w1[11:0], w0[11:0]}));
    check("single_detect", 64'(det_a), 64'({det_m_a[1], det_m_a[0]}));

    // Reset at cycle 30 of a frame
    single_a = 1'b0;
    n = 0;
    while (cs_a !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("rst_frame_start", 64'(cs_a), 64'(0));
    repeat (30) @(negedge clk);
    #1 rst_a = 1'b1;
    #1;
    check("rst_async_cs", 64'(cs_a), 64'(1));
    check("rst_async_sclk", 64'(sclk_a), 64'(1));
    valids = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (valid_a === 1'b1) valids++; end
    check("rst_no_valid", 64'(valids), 64'(0));
    check("rst_sample_zero", 64'(sample_a), 64'(0));
    det_m_a[0] = 1'b0; det_m_a[1] = 1'b0;
    hi_a = 12'd800; lo_a = 12'd600;
    rst_a = 1'b0;
    frame_a(16'($urandom), 16'($urandom), f0);
    en_a = 1'b0;

    // Wide instance: enable dropped mid-frame, frame completes then IDLE
    for (int i = 0; i < 4; i++) word_b[i] = 16'($urandom);
    word_b[2][11:0] = 12'd800;
    en_b = 1'b1;
    n = 0;
    while (cs_b !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("b_cs_fall", 64'(cs_b), 64'(0));
    n = 0; falls = 0; prev_cs = int'(sclk_b);
    while (cs_b === 1'b0 && n < 100) begin
      if (n == 10) en_b = 1'b0;
      @(negedge clk); n++;
      if (prev_cs == 0 && sclk_b === 1'b1) falls++;
      prev_cs = int'(sclk_b);
    end
    check("b_frame_len", 64'(n), 64'(32));
    check("b_sclk_rises", 64'(falls), 64'(16));
    check("b_valid", 64'(valid_b), 64'(1));
    for (int i = 0; i < 4; i++) begin
      det_m_b[i] = upd(det_m_b[i], word_b[i][11:0], hi_b, lo_b);
      check($sformatf("b_sample%0d", i), 64'(sample_b[i*12 +: 12]), 64'(word_b[i][11:0]));
      check($sformatf("b_detect%0d", i), 64'(det_b[i]), 64'(det_m_b[i]));
    end
    @(negedge clk);
    check("b_valid_drop", 64'(valid_b), 64'(0));
    n = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (cs_b === 1'b0) n++; end
    check("b_idle_after", 64'(n), 64'(0));
    check("b_idle_busy", 64'(busy_b), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
